// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wibone memory arbiter with fair tie-break and burst-safe grant hold.
// Optional stall watchdog compiled in with `define WB_MEM_ARBITER_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [2*aw-1:0]   wbm_adr_i,
  input  logic [2*dw-1:0]   wbm_dat_i,
  input  logic [2*dw/8-1:0] wbm_sel_i,
  input  logic [1:0]        wbm_we_i,
  input  logic [5:0]        wbm_cti_i,
  input  logic [3:0]        wbm_bte_i,
  input  logic [1:0]        wbm_cyc_i,
  input  logic [1:0]        wbm_stb_i,
  output logic [dw-1:0]     wbm_dat_o,
  output logic [1:0]        wbm_ack_o,
  output logic [1:0]        wbm_err_o,
  output logic [1:0]        wbm_rty_o,
  output logic [aw-1:0]     wbs_adr_o,
  output logic [dw-1:0]     wbs_dat_o,
  output logic [dw/8-1:0]   wbs_sel_o,
  output logic              wbs_we_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  input  logic [dw-1:0]     wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a master owns the slave from grant until it drops cyc; the slave
  // sees the owner's cyc/stb unchanged and its ack/err/rty go only to the owner.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_ABORT = 2'd2} state_t;

  state_t r_state, w_next_state;
  logic   r_grant, w_next_grant;
  logic   r_last, w_next_last;
  logic   w_cyc_g, w_stb_g;
  logic   w_timeout;

  assign w_cyc_g = r_grant ? wbm_cyc_i[1] : wbm_cyc_i[0];
  assign w_stb_g = r_grant ? wbm_stb_i[1] : wbm_stb_i[0];

  assign wbs_adr_o = r_grant ? wbm_adr_i[2*aw-1:aw]         : wbm_adr_i[aw-1:0];
  assign wbs_dat_o = r_grant ? wbm_dat_i[2*dw-1:dw]         : wbm_dat_i[dw-1:0];
  assign wbs_sel_o = r_grant ? wbm_sel_i[2*dw/8-1:dw/8]     : wbm_sel_i[dw/8-1:0];
  assign wbs_we_o  = r_grant ? wbm_we_i[1]                  : wbm_we_i[0];
  assign wbs_cti_o = r_grant ? wbm_cti_i[5:3]               : wbm_cti_i[2:0];
  assign wbs_bte_o = r_grant ? wbm_bte_i[3:2]               : wbm_bte_i[1:0];
  assign wbm_dat_o = wbs_dat_i;
  assign o_dbg_state = r_state;

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  logic [15:0] r_wdog;

  // Counts stalled strobe cycles of the current owner; any slave response restarts it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wdog <= '0;
    end else if (r_state != S_BUSY || w_timeout) begin
      r_wdog <= '0;
    end else if (wbs_ack_i || wbs_err_i || wbs_rty_i) begin
      r_wdog <= '0;
    end else if (w_cyc_g && w_stb_g) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = (r_wdog == 16'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^(16'(TIMEOUT));
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_last  <= w_next_last;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_last  = r_last;
    wbs_cyc_o    = 1'b0;
    wbs_stb_o    = 1'b0;
    wbm_ack_o    = 2'b00;
    wbm_err_o    = 2'b00;
    wbm_rty_o    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|wbm_cyc_i) begin
          w_next_state = S_BUSY;
          // On a tie the master not served last wins.
          w_next_grant = (&wbm_cyc_i) ? ~r_last : wbm_cyc_i[1];
        end
      end
      S_BUSY: begin
        if (!w_cyc_g) begin
          w_next_state = S_IDLE;
          w_next_last  = r_grant;
        end else if (w_timeout) begin
          wbm_err_o[r_grant] = 1'b1;
          w_next_state       = S_ABORT;
        end else begin
          wbs_cyc_o          = 1'b1;
          wbs_stb_o          = w_stb_g;
          wbm_ack_o[r_grant] = wbs_ack_i;
          wbm_err_o[r_grant] = wbs_err_i;
          wbm_rty_o[r_grant] = wbs_rty_i;
        end
      end
      S_ABORT: begin
        if (!w_cyc_g) begin
          w_next_state = S_IDLE;
          w_next_last  = r_grant;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: arbitration order, burst hold, response routing,
// async reset and the optional stall watchdog (TIMEOUT = 16).
module tb_wb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic              clk;
  logic              rst_n;
  logic [2*AW-1:0]   wbm_adr_i;
  logic [2*DW-1:0]   wbm_dat_i;
  logic [2*DW/8-1:0] wbm_sel_i;
  logic [1:0]        wbm_we_i;
  logic [5:0]        wbm_cti_i;
  logic [3:0]        wbm_bte_i;
  logic [1:0]        wbm_cyc_i;
  logic [1:0]        wbm_stb_i;
  logic [DW-1:0]     wbm_dat_o;
  logic [1:0]        wbm_ack_o;
  logic [1:0]        wbm_err_o;
  logic [1:0]        wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic              wbs_we_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_cyc_o;
  logic              wbs_stb_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i;
  logic              wbs_err_i;
  logic              wbs_rty_i;
  logic [1:0]        dbg_state;

  int n_tests;
  int n_fail;
  logic seen_bad;

  wb_mem_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver
  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    wbm_cyc_i[m]          = cyc;
    wbm_stb_i[m]          = stb;
    wbm_we_i[m]           = we;
    wbm_adr_i[m*AW +: AW] = adr;
    wbm_dat_i[m*DW +: DW] = dat;
    wbm_sel_i[m*4 +: 4]   = 4'hF;
    wbm_cti_i[m*3 +: 3]   = cti;
    wbm_bte_i[m*2 +: 2]   = 2'b00;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cti_i = '0; wbm_bte_i = '0; wbm_cyc_i = '0; wbm_stb_i = '0;
    wbs_dat_i = 32'hCAFE0001; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

    // Reset holds everything quiet even with requests pending
    tick();
    wbm_cyc_i = 2'b11; wbm_stb_i = 2'b11; wbs_ack_i = 1'b1;
    tick();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cyc", wbs_cyc_o, 1'b0);
    chk("rst_ack", wbm_ack_o, 2'b00);
    chk("rst_dat_bcast", wbm_dat_o, 32'hCAFE0001);
    wbm_cyc_i = 2'b00; wbm_stb_i = 2'b00; wbs_ack_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Tie after reset: m0 first, then m1 after one idle cycle, next tie m0
    drive_m(0, 1, 1, 0, 32'h10, 32'h0, 3'b000);
    drive_m(1, 1, 1, 0, 32'h20, 32'h0, 3'b000);
    settle();
    chk("tie_idle_cyc", wbs_cyc_o, 1'b0);
    tick();
    chk("tie1_state", dbg_state, ST_BUSY);
    chk("tie1_adr", wbs_adr_o, 32'h10);
    wbs_ack_i = 1'b1;
    settle();
    chk("tie1_ack", wbm_ack_o, 2'b01);
    tick();
    wbs_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'h10, 32'h0, 3'b000);
    settle();
    chk("m0_release_cyc", wbs_cyc_o, 1'b0);
    tick();
    chk("gap_state", dbg_state, ST_IDLE);
    chk("gap_cyc", wbs_cyc_o, 1'b0);
    tick();
    chk("m1_grant_adr", wbs_adr_o, 32'h20);
    chk("m1_grant_cyc", wbs_cyc_o, 1'b1);
    wbs_ack_i = 1'b1;
    settle();
    chk("m1_ack", wbm_ack_o, 2'b10);
    tick();
    wbs_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 32'h20, 32'h0, 3'b000);
    tick();
    drive_m(0, 1, 1, 0, 32'h10, 32'h0, 3'b000);
    drive_m(1, 1, 1, 0, 32'h20, 32'h0, 3'b000);
    tick();
    chk("tie2_adr", wbs_adr_o, 32'h10);
    drive_m(0, 0, 0, 0, 32'h10, 32'h0, 3'b000);
    drive_m(1, 0, 0, 0, 32'h20, 32'h0, 3'b000);
    tick();
    tick();

    // Single write from m0
    drive_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 3'b000);
    settle();
    chk("wr_cyc_pre", wbs_cyc_o, 1'b0);
    tick();
    chk("wr_cyc", wbs_cyc_o, 1'b1);
    chk("wr_adr", wbs_adr_o, 32'h100);
    chk("wr_dat", wbs_dat_o, 32'hDEADBEEF);
    chk("wr_sel_we", {wbs_sel_o, wbs_we_o}, {4'hF, 1'b1});
    chk("wr_noack", wbm_ack_o, 2'b00);
    wbs_ack_i = 1'b1;
    settle();
    chk("wr_ack", wbm_ack_o, 2'b01);
    tick();
    wbs_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 3'b000);
    tick();
    chk("wr_done_state", dbg_state, ST_IDLE);

    // m0 incrementing burst with m1 waiting; then m1 read answered by err
    drive_m(0, 1, 1, 0, 32'h0, 32'h0, 3'b010);
    tick();
    drive_m(1, 1, 1, 0, 32'h200, 32'h0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      drive_m(0, 1, 1, 0, 32'(4 * i), 32'h0, (i == 3) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      settle();
      chk("burst_adr", wbs_adr_o, 32'(4 * i));
      chk("burst_cti", wbs_cti_o, (i == 3) ? 3'b111 : 3'b010);
      chk("burst_ack", wbm_ack_o, 2'b01);
      tick();
    end
    wbs_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'hC, 32'h0, 3'b000);
    settle();
    chk("burst_end_cyc", wbs_cyc_o, 1'b0);
    tick();
    chk("burst_gap_state", dbg_state, ST_IDLE);
    tick();
    chk("m1_after_burst_adr", wbs_adr_o, 32'h200);
    wbs_err_i = 1'b1;
    settle();
    chk("m1_err", wbm_err_o, 2'b10);
    chk("m1_err_noack", wbm_ack_o, 2'b00);
    tick();
    wbs_err_i = 1'b0;
    drive_m(1, 0, 0, 0, 32'h200, 32'h0, 3'b000);
    tick();

    // Reset during beat 2 of an m0 burst
    drive_m(0, 1, 1, 0, 32'h0, 32'h0, 3'b010);
    tick();
    wbs_ack_i = 1'b1;
    settle();
    chk("rb_beat1_ack", wbm_ack_o, 2'b01);
    tick();
    drive_m(0, 1, 1, 0, 32'h4, 32'h0, 3'b010);
    settle();
    chk("rb_beat2_cyc", wbs_cyc_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_async_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
    chk("rb_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b0);
    chk("rb_state", dbg_state, ST_IDLE);
    tick();
    wbs_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'h4, 32'h0, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();
    drive_m(0, 1, 1, 0, 32'h300, 32'h0, 3'b000);
    drive_m(1, 1, 1, 0, 32'h400, 32'h0, 3'b000);
    tick();
    chk("post_rst_tie_adr", wbs_adr_o, 32'h300);
    drive_m(0, 0, 0, 0, 32'h300, 32'h0, 3'b000);
    drive_m(1, 0, 0, 0, 32'h400, 32'h0, 3'b000);
    tick();
    tick();

    // Silent slave: watchdog abort, or indefinite stall without it
    drive_m(0, 1, 1, 0, 32'h500, 32'h0, 3'b000);
    tick();
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    seen_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (wbm_err_o != 2'b00 || !wbs_cyc_o) seen_bad = 1'b1;
      tick();
    end
    chk("wd_no_early_err", seen_bad, 1'b0);
    chk("wd_err_pulse", wbm_err_o, 2'b01);
    chk("wd_cyc_low", wbs_cyc_o, 1'b0);
    tick();
    chk("wd_abort_state", dbg_state, ST_ABORT);
    chk("wd_err_one_cycle", wbm_err_o, 2'b00);
    wbs_ack_i = 1'b1;
    settle();
    chk("wd_abort_ignores_ack", wbm_ack_o, 2'b00);
    wbs_ack_i = 1'b0;
`else
    seen_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (wbm_err_o != 2'b00 || !wbs_cyc_o) seen_bad = 1'b1;
      tick();
    end
    chk("stall_no_err", seen_bad, 1'b0);
    chk("stall_state", dbg_state, ST_BUSY);
`endif
    drive_m(0, 0, 0, 0, 32'h500, 32'h0, 3'b000);
    tick();
    chk("final_idle", dbg_state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
